// File: rtl/diabetes_pkg.sv
// Shared definitions for the binary-to-BCD display path.
//   DIGIT_W     : width of one packed BCD digit
//   bcd_digit_t : one BCD digit
//   state_t     : converter sequencing states
//   max_dec()   : largest value representable in a given number of decimal digits
package diabetes_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  // 10^digits - 1, evaluated at elaboration time.
  function automatic int unsigned max_dec(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/dabble_nibble.sv
// Double-dabble correction cell: a BCD digit of 5..9 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   d : BCD digit before correction
//   q : corrected digit (never carries out of 4 bits)
module dabble_nibble
  import diabetes_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5 && d <= 4'd9) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential double-dabble binary to packed-BCD converter feeding the HEX
// digit drivers. One conversion per start accepted in IDLE; fixed latency of
// BIN_W+1 edges from the accepting edge to the edge that raises done.
// Operands above 10^DIGITS-1 are saturated to that value and flagged by ovf.
// Optional feature macro: BCD_LEADING_BLANK_EN (leading-zero blank mask).
// Ports:
//   ADC_CLK_10 : system clock
//   RESET_N    : asynchronous active-low reset
//   start      : conversion request, sampled only in IDLE
//   bin        : unsigned operand, captured on the accepting edge
//   busy       : high while converting and in the final DONE cycle
//   done       : one-cycle pulse, bcd/ovf/blank valid from this cycle on
//   bcd        : packed BCD result, digit 0 in bits [3:0]
//   ovf        : operand was saturated to 10^DIGITS-1
//   blank      : per-digit leading-zero blank mask (0 unless macro defined)
module bin_to_bcd_serial #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                ADC_CLK_10,
  input  logic                RESET_N,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*4-1:0] bcd,
  output logic                ovf,
  output logic [DIGITS-1:0]   blank
);

  import diabetes_pkg::*;

  localparam int unsigned BCD_W   = DIGITS * DIGIT_W;
  localparam int unsigned SR_W    = BCD_W + BIN_W;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_DEC = max_dec(DIGITS);
  localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;
  // Saturation only exists when the operand range exceeds the decimal range.
  localparam bit SAT_EN = (BIN_MAX > 64'(MAX_DEC));

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sreg;
  logic             ovf_pend;
  logic [BCD_W-1:0] corr;
  logic [SR_W-1:0]  sreg_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    dabble_nibble u_nib (
      .d (sreg[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .q (corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Correct all digits in parallel, then shift the whole register left by one.
  assign sreg_next = {corr[BCD_W-2:0], sreg[BIN_W-1:0], 1'b0};

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS-1:0] blank_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_zero
    assign dig_zero[g] = (sreg[BIN_W + g*DIGIT_W +: DIGIT_W] == '0);
    if (g == 0) begin : g_lsd
      assign blank_next[g] = 1'b0;
    end else begin : g_upper
      assign blank_next[g] = &dig_zero[DIGITS-1:g];
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge ADC_CLK_10 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      sreg     <= '0;
      ovf_pend <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
      blank    <= BLANK_RST;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(BIN_W);
            state <= CONVERT;
            if (SAT_EN && (32'(bin) > MAX_DEC)) begin
              sreg     <= SR_W'(BIN_W'(MAX_DEC));
              ovf_pend <= 1'b1;
            end else begin
              sreg     <= SR_W'(bin);
              ovf_pend <= 1'b0;
            end
          end
        end
        CONVERT: begin
          sreg <= sreg_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= sreg[SR_W-1 -: BCD_W];
          ovf   <= ovf_pend;
`ifdef BCD_LEADING_BLANK_EN
          blank <= blank_next;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed self-checking bench for bin_to_bcd_serial (BIN_W=14, DIGITS=4).
module tb_bin_to_bcd_serial;

  logic        ADC_CLK_10;
  logic        RESET_N;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  blank;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [3:0] BL_RST  = 4'b1110;
  localparam logic [3:0] BL_ZERO = 4'b1110;
  localparam logic [3:0] BL_ONE  = 4'b1110;
  localparam logic [3:0] BL_TWO  = 4'b1100;
`else
  localparam logic [3:0] BL_RST  = 4'b0000;
  localparam logic [3:0] BL_ZERO = 4'b0000;
  localparam logic [3:0] BL_ONE  = 4'b0000;
  localparam logic [3:0] BL_TWO  = 4'b0000;
`endif

  bin_to_bcd_serial #(
    .BIN_W  (14),
    .DIGITS (4)
  ) dut (
    .ADC_CLK_10 (ADC_CLK_10),
    .RESET_N    (RESET_N),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .ovf        (ovf),
    .blank      (blank)
  );

  initial ADC_CLK_10 = 1'b0;
  always #5 ADC_CLK_10 = ~ADC_CLK_10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One start pulse; lat = edges from accepting edge to first edge showing done.
  task automatic convert(input logic [13:0] v, output int lat);
    @(negedge ADC_CLK_10);
    bin   = v;
    start = 1'b1;
    @(posedge ADC_CLK_10);
    @(negedge ADC_CLK_10);
    start = 1'b0;
    bin   = 14'h3fff;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'd15);
  endtask

  initial begin
    int lat;
    int dcount;
    int first;
    int prev;
    int idx;
    logic [15:0] seq_exp [4];
    logic [13:0] seq_bin [4];

    RESET_N = 1'b0;
    start   = 1'b0;
    bin     = '0;
    #1;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_blank", 32'(blank), 32'(BL_RST));
    repeat (2) @(negedge ADC_CLK_10);
    RESET_N = 1'b1;

    convert(14'd1234, lat);
    check("bcd_1234", 32'(bcd), 32'h1234);
    check("ovf_1234", 32'(ovf), 32'd0);
    check("blank_1234", 32'(blank), 32'd0);
    @(posedge ADC_CLK_10);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_back_low", 32'(busy), 32'd0);

    convert(14'd0, lat);
    check("bcd_0", 32'(bcd), 32'h0000);
    check("blank_0", 32'(blank), 32'(BL_ZERO));

    convert(14'd16383, lat);
    check("bcd_sat", 32'(bcd), 32'h9999);
    check("ovf_sat", 32'(ovf), 32'd1);

    convert(14'd9999, lat);
    check("bcd_9999", 32'(bcd), 32'h9999);
    check("ovf_9999", 32'(ovf), 32'd0);

    convert(14'd7, lat);
    check("bcd_7", 32'(bcd), 32'h0007);
    check("blank_7", 32'(blank), 32'(BL_ONE));
    check("ovf_7", 32'(ovf), 32'd0);

    // Starts during CONVERT (edge E+5) and DONE (edge E+15) are ignored.
    @(negedge ADC_CLK_10);
    bin   = 14'd42;
    start = 1'b1;
    @(posedge ADC_CLK_10);
    dcount = 0;
    first  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ADC_CLK_10);
      start = (k == 5 || k == 15);
      bin   = (k == 5 || k == 15) ? 14'd999 : 14'd0;
      @(posedge ADC_CLK_10);
      #1;
      if (done) begin
        dcount++;
        if (first < 0) first = k;
      end
    end
    check("ignore_done_count", 32'(dcount), 32'd1);
    check("ignore_latency", 32'(first), 32'd15);
    check("bcd_42", 32'(bcd), 32'h0042);
    check("blank_42", 32'(blank), 32'(BL_TWO));
    check("ignore_idle_after", 32'(busy), 32'd0);

    // Abort a conversion by asynchronous reset.
    @(negedge ADC_CLK_10);
    bin   = 14'd5678;
    start = 1'b1;
    @(posedge ADC_CLK_10);
    @(negedge ADC_CLK_10);
    start = 1'b0;
    repeat (7) @(posedge ADC_CLK_10);
    @(negedge ADC_CLK_10);
    #2;
    RESET_N = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge ADC_CLK_10);
    RESET_N = 1'b1;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    convert(14'd5678, lat);
    check("bcd_5678", 32'(bcd), 32'h5678);

    // start held high: a new conversion every 16 cycles.
    seq_bin[0] = 14'd1;    seq_exp[0] = 16'h0001;
    seq_bin[1] = 14'd10;   seq_exp[1] = 16'h0010;
    seq_bin[2] = 14'd100;  seq_exp[2] = 16'h0100;
    seq_bin[3] = 14'd1000; seq_exp[3] = 16'h1000;
    @(negedge ADC_CLK_10);
    bin   = seq_bin[0];
    start = 1'b1;
    @(posedge ADC_CLK_10);
    idx  = 0;
    prev = 0;
    for (int k = 1; k <= 80 && idx < 4; k++) begin
      @(posedge ADC_CLK_10);
      #1;
      if (done) begin
        check("held_bcd", 32'(bcd), 32'(seq_exp[idx]));
        check("held_spacing", 32'(k - prev), (idx == 0) ? 32'd15 : 32'd16);
        prev = k;
        idx++;
        if (idx == 4) start = 1'b0;
        else          bin   = seq_bin[idx];
      end
    end
    start = 1'b0;
    check("held_count", 32'(idx), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
